core_data_responder: RTL and testbench
======================================

Name: core_data_responder

Overview:
Responder (slave) end of the core data-bus handshake that the load/store unit initiates.
- Accepts single-word requests on data_start and drives a synchronous SRAM port.
- Inserts programmable wait states, then returns completion as a one-cycle data_ready pulse, with read data for loads.
- Sits between the core's data port and the data RAM; it is also the reference slave model for core benches.

Parameters:
WAIT_STATES, 2, idle cycles between request acceptance and SRAM issue (0 allowed)
MEM_LATENCY, 1, SRAM read latency in cycles from mem_en to valid mem_rdata (>=1)
MEM_AW, 12, SRAM word-address width; valid word addresses are 0 .. 2**MEM_AW-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
data_start  in  1  one-cycle request strobe; data_addr/data_write/data_data_wr/data_data_be valid same cycle
data_addr  in  30  word address (ptr)
data_write  in  1  1=store, 0=load
data_data_wr  in  32  store data
data_data_be  in  4  byte enables (store only)
data_ready  out  1  one-cycle completion pulse
data_data_rd  out  32  load data, valid when data_ready on a load; holds last load value otherwise
bad_addr  out  1  pulses with data_ready when the request address is out of range
overrun  out  1  sticky; set when a request is dropped; cleared only by reset
busy  out  1  1 when state != IDLE or the pending buffer is valid
mem_en  out  1  SRAM access strobe, one cycle per access
mem_we  out  1  SRAM write enable, qualified by mem_en
mem_addr  out  MEM_AW  SRAM word address
mem_be  out  4  SRAM byte write mask
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data

Behaviour:
- Reset (synchronous, sampled on rising clk with rst_n=0), from any state including mid-access:
  - All outputs go to 0.
  - State goes to IDLE; pending buffer is invalidated; in-flight request is discarded.
  - No data_ready is issued for the discarded request.
- FSM states: IDLE, WAIT, ISSUE, RDWAIT, RESP.
- IDLE: data_start=1 latches {addr, write, wdata, be} into the active request register.
  - Next state is WAIT if WAIT_STATES>0, else ISSUE.
- WAIT: counter loaded with WAIT_STATES-1 on entry, decrements each cycle; at 0 go to ISSUE.
- ISSUE: drive mem_en=1 for exactly one cycle.
  - mem_we=write, mem_addr=addr[MEM_AW-1:0], mem_be=be, mem_wdata=wdata.
  - Store: next state RESP.
  - Load: next state RDWAIT, counting MEM_LATENCY cycles.
- RDWAIT: in the cycle mem_rdata is valid (MEM_LATENCY cycles after ISSUE), register it into data_data_rd; next state RESP.
- RESP: data_ready=1 for exactly one cycle.
- Latency, with data_start sampled at cycle T:
  - Store: data_ready at T+WAIT_STATES+2.
  - Load: data_ready at T+WAIT_STATES+2+MEM_LATENCY.
- Out of range (data_addr[29:MEM_AW] != 0):
  - The ISSUE cycle keeps mem_en=0.
  - A load returns data_data_rd=0.
  - A store is dropped.
  - The FSM still walks the same states with the same latency; bad_addr=1 in the RESP cycle.
- Pending buffer (one entry) for requests arriving while not in IDLE or RESP:
  - Buffer empty: the request is stored.
  - Buffer full: the request is dropped and overrun is set.
- Leaving RESP:
  - Pending valid and no new data_start: launch pending (WAIT/ISSUE), buffer cleared.
  - Pending valid and data_start: launch pending; the new request is stored in the buffer.
  - Pending empty and data_start: launch the new request directly (back-to-back, no IDLE cycle).
  - Otherwise: go to IDLE.
- Requests complete strictly in acceptance order; exactly one data_ready per accepted, non-dropped request.
- mem_* outputs hold their last values when mem_en=0; only mem_en is meaningful to the SRAM.
- data_data_be is ignored for loads; mem_be is forced to 4'b0000 on loads.

Decomposition:
- core/uarch.sv gains struct data_req {ptr addr; logic write; word wdata; logic[3:0] be} for the active and pending registers.
- The existing word/ptr types are reused.
- One sub-module, core_data_req_buf: the one-entry pending buffer.
  - Ports: push, pop, in data_req, out data_req, valid, drop.
  - drop pulses on push while full without pop.
  - It is the source of overrun.

Test Plan:
- Reset, then store addr=0x10, data=0xDEADBEEF, be=4'b1111 (WAIT_STATES=2) -> mem_en/mem_we high at T+3 with mem_addr=0x10; data_ready at T+4; bad_addr=0.
- Load addr=0x10 after that store, MEM_LATENCY=1 -> data_ready at T+5 with data_data_rd=0xDEADBEEF.
- Store with be=4'b0011 data=0x11112222 over 0xDEADBEEF, then load -> 0xDEAD2222.
- Load addr=0x1000 with MEM_AW=12 -> mem_en never asserted; data_ready at T+5 with data_data_rd=0, bad_addr=1.
- Three data_start pulses on consecutive cycles -> first and second complete in order with two data_ready pulses; third is dropped; overrun=1; busy falls after the second completion.
- rst_n=0 during WAIT of a load -> next cycle all outputs 0 and state IDLE; no data_ready is ever seen for that load; a following load completes normally.

Source files
------------

// File: rtl/core_data_responder_pkg.sv
// Shared types for the core data-bus responder.
// Request bundle, word/ptr types and FSM encodings.
package core_data_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [29:0] ptr_t;

  typedef struct packed {
    ptr_t        addr;
    logic        write;
    word_t       wdata;
    logic [3:0]  be;
  } data_req_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

endpackage

// File: rtl/core_data_responder_req_buf.sv
// One-entry pending request buffer.
// drop flags a push that finds the entry full with no pop.
module core_data_req_buf
  import core_data_responder_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  data_req_t in_req,
  output data_req_t out_req,
  output logic      valid,
  output logic      drop
);

  data_req_t req_q, req_d;
  logic      valid_q, valid_d;

  always_comb begin
    req_d   = req_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (pop) valid_d = 1'b0;
    if (push) begin
      if (!valid_q || pop) begin
        req_d   = in_req;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign out_req = req_q;
  assign valid   = valid_q;

endmodule

// File: rtl/core_data_responder.sv
// Responder end of the core data-bus handshake.
// Wait states, SRAM issue, read latency, one pending slot.
module core_data_responder
  import core_data_responder_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MEM_AW      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_start,
  input  logic [29:0]       data_addr,
  input  logic              data_write,
  input  logic [31:0]       data_data_wr,
  input  logic [3:0]        data_data_be,
  output logic              data_ready,
  output logic [31:0]       data_data_rd,
  output logic              bad_addr,
  output logic              overrun,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [15:0] WS_LOAD =
    (WAIT_STATES > 0) ? 16'(WAIT_STATES - 1) : 16'd0;
  localparam logic [15:0] ML_LOAD =
    (MEM_LATENCY > 0) ? 16'(MEM_LATENCY - 1) : 16'd0;

  function automatic logic in_range(ptr_t a);
    return (a >> MEM_AW) == '0;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  data_req_t         act_q, act_d;
  word_t             rd_q, rd_d;
  logic              ovr_q, ovr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  word_t             mem_wdata_q, mem_wdata_d;

  data_req_t new_req, pend_req, launch_req;
  logic      pend_valid, pend_push, pend_pop;
  logic      pend_drop, launch;

  assign new_req = '{
    addr:  data_addr,
    write: data_write,
    wdata: data_data_wr,
    be:    data_data_be
  };

  assign pend_pop  = (state_q == S_RESP) && pend_valid;
  assign pend_push = data_start && (state_q != S_IDLE) &&
                     !((state_q == S_RESP) && !pend_valid);

  core_data_req_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (pend_push),
    .pop     (pend_pop),
    .in_req  (new_req),
    .out_req (pend_req),
    .valid   (pend_valid),
    .drop    (pend_drop)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    rd_d       = rd_q;
    launch     = 1'b0;
    launch_req = new_req;
    unique case (state_q)
      S_IDLE: begin
        if (data_start) launch = 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ISSUE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      S_ISSUE: begin
        if (act_q.write) begin
          state_d = S_RESP;
        end else begin
          state_d = S_RDWAIT;
          cnt_d   = ML_LOAD;
        end
      end
      S_RDWAIT: begin
        if (cnt_q == '0) begin
          rd_d    = in_range(act_q.addr) ? mem_rdata : '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RESP: begin
        if (pend_valid) begin
          launch     = 1'b1;
          launch_req = pend_req;
        end else if (data_start) begin
          launch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      act_d   = launch_req;
      cnt_d   = WS_LOAD;
      state_d = (WAIT_STATES > 0) ? S_WAIT : S_ISSUE;
    end
  end

  // SRAM port is registered on entry to ISSUE; holds otherwise
  always_comb begin
    mem_en_d    = (state_d == S_ISSUE) && in_range(act_d.addr);
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if (mem_en_d) begin
      mem_we_d    = act_d.write;
      mem_addr_d  = act_d.addr[MEM_AW-1:0];
      mem_be_d    = act_d.write ? act_d.be : 4'b0000;
      mem_wdata_d = act_d.wdata;
    end
    ovr_d = ovr_q | pend_drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      act_q       <= '0;
      rd_q        <= '0;
      ovr_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      rd_q        <= rd_d;
      ovr_q       <= ovr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign data_ready   = (state_q == S_RESP);
  assign bad_addr     = (state_q == S_RESP) && !in_range(act_q.addr);
  assign data_data_rd = rd_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != S_IDLE) || pend_valid;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_core_data_responder.sv
// Scoreboard bench for core_data_responder with an SRAM model.
// Expected responses come from a cycle-level transaction model.
module tb_core_data_responder;

  localparam int WS = 2;
  localparam int ML = 1;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_start = 1'b0;
  logic [29:0] data_addr = '0;
  logic        data_write = 1'b0;
  logic [31:0] data_data_wr = '0;
  logic [3:0]  data_data_be = '0;
  logic        data_ready;
  logic [31:0] data_data_rd;
  logic        bad_addr;
  logic        overrun;
  logic        busy;
  logic        mem_en;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  core_data_responder #(
    .WAIT_STATES (WS),
    .MEM_LATENCY (ML),
    .MEM_AW      (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_start   (data_start),
    .data_addr    (data_addr),
    .data_write   (data_write),
    .data_data_wr (data_data_wr),
    .data_data_be (data_data_be),
    .data_ready   (data_ready),
    .data_data_rd (data_data_rd),
    .bad_addr     (bad_addr),
    .overrun      (overrun),
    .busy         (busy),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sram [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  typedef struct {
    int          done;
    int          issue;
    bit          write;
    bit          bad;
    logic [31:0] data;
    logic [AW-1:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int last_done = -1;
  int prev_done = -1;
  bit ovr_exp = 1'b0;
  int ovr_cyc = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  task automatic model_accept(input bit w, input logic [29:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    int   nout;
    exp_t e;
    int   t0;
    logic [AW-1:0] wa;
    nout = ((last_done > cyc) ? 1 : 0) + ((prev_done > cyc) ? 1 : 0);
    if (nout >= 2) begin
      if (!ovr_exp) ovr_cyc = cyc + 1;
      ovr_exp = 1'b1;
    end else begin
      wa      = a[AW-1:0];
      e.write = w;
      e.bad   = (a >> AW) != 0;
      t0      = (last_done > cyc) ? last_done : cyc;
      e.done  = t0 + WS + 2 + (w ? 0 : ML);
      e.issue = e.done - 1 - (w ? 0 : ML);
      e.maddr = wa;
      e.wdata = d;
      e.be    = be;
      e.data  = (w || e.bad) ? 32'h0 : ref_mem[wa];
      if (w && !e.bad)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[wa][8*b +: 8] = d[8*b +: 8];
      sb.push_back(e);
      prev_done = last_done;
      last_done = e.done;
    end
  endtask

  task automatic step(input bit req, input bit w, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    #1;
    data_start   = req;
    data_write   = w;
    data_addr    = a;
    data_data_wr = d;
    data_data_be = be;
    if (req) model_accept(w, a, d, be);
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while ((sb.size() != 0 || last_done >= cyc) && n < 300) begin
      step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(sb.size()), 32'h0);
    step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_data_ready", 32'(data_ready), 32'h0);
    chk("rst_data_rd", data_data_rd, 32'h0);
    chk("rst_bad_addr", 32'(bad_addr), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  exp_t m_e;
  bit   m_en;
  bit   m_rdy;
  int   m_idx;

  always @(negedge clk) begin
    if (rst_n) begin
      m_en  = 1'b0;
      m_idx = 0;
      foreach (sb[i])
        if (sb[i].issue == cyc && !sb[i].bad) begin
          m_en  = 1'b1;
          m_idx = i;
        end
      chk("mem_en", 32'(mem_en), 32'(m_en));
      if (m_en && mem_en) begin
        m_e = sb[m_idx];
        chk("mem_addr", 32'(mem_addr), 32'(m_e.maddr));
        chk("mem_we", 32'(mem_we), 32'(m_e.write));
        chk("mem_be", 32'(mem_be), m_e.write ? 32'(m_e.be) : 32'h0);
        if (m_e.write) chk("mem_wdata", mem_wdata, m_e.wdata);
      end
      while (sb.size() != 0 && sb[0].done < cyc) begin
        chk("ready_missing", 32'h0, 32'h1);
        void'(sb.pop_front());
      end
      m_rdy = (sb.size() != 0) && (sb[0].done == cyc);
      chk("data_ready", 32'(data_ready), 32'(m_rdy));
      if (m_rdy) begin
        m_e = sb.pop_front();
        chk("bad_addr", 32'(bad_addr), 32'(m_e.bad));
        if (!m_e.write) last_rd = m_e.data;
      end else begin
        chk("bad_addr_idle", 32'(bad_addr), 32'h0);
      end
      chk("data_data_rd", data_data_rd, last_rd);
      chk("overrun", 32'(overrun), 32'(ovr_exp && cyc >= ovr_cyc));
      chk("busy", 32'(busy), 32'(last_done >= cyc));
    end
  end

  initial begin
    logic [29:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    step(1'b1, 1'b1, 30'h10, 32'hDEADBEEF, 4'b1111);
    idle_wait();
    step(1'b1, 1'b0, 30'h10, 32'h0, 4'b1111);
    idle_wait();
    step(1'b1, 1'b1, 30'h10, 32'h11112222, 4'b0011);
    idle_wait();
    step(1'b1, 1'b0, 30'h10, 32'h0, 4'b0000);
    idle_wait();
    step(1'b1, 1'b0, 30'h1000, 32'h0, 4'b0000);
    idle_wait();
    step(1'b1, 1'b1, 30'h1000, 32'h55AA55AA, 4'b1111);
    idle_wait();

    step(1'b1, 1'b1, 30'h20, 32'hCAFEF00D, 4'b1111);
    step(1'b1, 1'b0, 30'h20, 32'h0, 4'b0000);
    step(1'b1, 1'b1, 30'h21, 32'h12345678, 4'b1111);
    step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    idle_wait();

    step(1'b1, 1'b0, 30'h10, 32'h0, 4'b0000);
    @(negedge clk);
    #1;
    data_start = 1'b0;
    rst_n      = 1'b0;
    sb.delete();
    last_done = -1;
    prev_done = -1;
    ovr_exp   = 1'b0;
    last_rd   = 32'h0;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 30'h20, 32'h0, 4'b0000);
    idle_wait();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = 30'h1000 + 30'($urandom_range(0, 255));
      else
        a = 30'($urandom_range(0, 15));
      step($urandom_range(0, 99) < 45, 1'($urandom_range(0, 1)), a,
           $urandom, 4'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    idle_wait();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
